// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory port arbiter.
//   arb_state_e : sequencer states (IDLE, ISSUE, WAIT)
//   port_e      : requester identity (PORT_I, PORT_D)
//   BURST_DEFAULT / OFFSET_BITS_DEFAULT : default line geometry
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_e;

  typedef enum logic {
    PORT_I,
    PORT_D
  } port_e;

  localparam logic [4:0]  BURST_DEFAULT       = 5'd16;
  localparam int unsigned OFFSET_BITS_DEFAULT = 6;

  function automatic port_e other_port(input port_e p);
    return (p == PORT_I) ? PORT_D : PORT_I;
  endfunction

endpackage

// File: rtl/mem_arb_req_latch.sv
// Per-port request capture for the memory port arbiter.
// A request seen while not pending sets the pending flag and snapshots
// address, operation and write line; further requests are ignored until
// the arbiter clears the flag on completion.
// Ports:
//   clk, resetn  : clock, synchronous active-low reset
//   i_req        : request strobe (read or write)
//   i_we         : request is a write
//   i_addr       : line address
//   i_wdata      : write line
//   i_clear      : transaction for this port has completed
//   o_pend       : request pending (also the port's wait flag)
//   o_we/o_addr/o_wdata : latched request
module mem_arb_req_latch
  import mem_arb_pkg::*;
#(
  parameter int unsigned LINE_BITS = 512
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 i_req,
  input  logic                 i_we,
  input  logic [31:0]          i_addr,
  input  logic [LINE_BITS-1:0] i_wdata,
  input  logic                 i_clear,
  output logic                 o_pend,
  output logic                 o_we,
  output logic [31:0]          o_addr,
  output logic [LINE_BITS-1:0] o_wdata
);

  logic                 r_pend;
  logic                 r_we;
  logic [31:0]          r_addr;
  logic [LINE_BITS-1:0] r_wdata;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_pend  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (i_clear) begin
      r_pend <= 1'b0;
    end else if (i_req && !r_pend) begin
      r_pend  <= 1'b1;
      r_we    <= i_we;
      r_addr  <= i_addr;
      r_wdata <= i_wdata;
    end
  end

  assign o_pend  = r_pend;
  assign o_we    = r_we;
  assign o_addr  = r_addr;
  assign o_wdata = r_wdata;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one line-burst memory master between the I-cache refill port
// (read only) and the D-cache refill/writeback port. Each port's request
// is latched, one line transaction runs at a time, and contention is
// resolved round-robin. A port's wait_data is its pending flag.
// Ports:
//   clk, resetn                       : clock, synchronous active-low reset
//   i_address/i_read/i_wait_data/i_reddata : I-cache port
//   d_address/d_read/d_write/d_writedata/d_wait_data/d_reddata : D-cache port
//   mem_*                             : burst memory master
//   stat_i_stall/stat_d_stall/stat_conflicts : counters, live only when
//     MEM_ARB_STATS_EN is defined, otherwise tied to zero
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter logic [4:0]  BURST       = BURST_DEFAULT,
  parameter int unsigned LINE_BITS   = BURST * 32,
  parameter int unsigned OFFSET_BITS = OFFSET_BITS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [31:0]          i_address,
  input  logic                 i_read,
  output logic                 i_wait_data,
  output logic [LINE_BITS-1:0] i_reddata,
  input  logic [31:0]          d_address,
  input  logic                 d_read,
  input  logic                 d_write,
  input  logic [LINE_BITS-1:0] d_writedata,
  output logic                 d_wait_data,
  output logic [LINE_BITS-1:0] d_reddata,
  output logic [31:0]          mem_address,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [LINE_BITS-1:0] mem_writedata,
  output logic [4:0]           mem_burstcount,
  input  logic                 mem_wait_data,
  input  logic [LINE_BITS-1:0] mem_reddata,
  output logic [31:0]          stat_i_stall,
  output logic [31:0]          stat_d_stall,
  output logic [31:0]          stat_conflicts
);

  arb_state_e           r_state, w_state_next;
  port_e                r_grant, w_grant_next;
  port_e                r_last_grant;
  logic [LINE_BITS-1:0] r_line_buf;

  logic                 w_i_pend, w_i_we, w_d_pend, w_d_we;
  logic [31:0]          w_i_addr, w_d_addr, w_sel_addr;
  logic [LINE_BITS-1:0] w_i_wdata, w_d_wdata;
  logic                 w_sel_we, w_done;

  mem_arb_req_latch #(.LINE_BITS(LINE_BITS)) u_req_i (
    .clk     (clk),
    .resetn  (resetn),
    .i_req   (i_read),
    .i_we    (1'b0),
    .i_addr  (i_address),
    .i_wdata ('0),
    .i_clear (w_done && (r_grant == PORT_I)),
    .o_pend  (w_i_pend),
    .o_we    (w_i_we),
    .o_addr  (w_i_addr),
    .o_wdata (w_i_wdata)
  );

  // d_write takes priority over d_read when both are raised.
  mem_arb_req_latch #(.LINE_BITS(LINE_BITS)) u_req_d (
    .clk     (clk),
    .resetn  (resetn),
    .i_req   (d_read || d_write),
    .i_we    (d_write),
    .i_addr  (d_address),
    .i_wdata (d_writedata),
    .i_clear (w_done && (r_grant == PORT_D)),
    .o_pend  (w_d_pend),
    .o_we    (w_d_we),
    .o_addr  (w_d_addr),
    .o_wdata (w_d_wdata)
  );

  assign w_sel_we   = (r_grant == PORT_D) ? w_d_we   : w_i_we;
  assign w_sel_addr = (r_grant == PORT_D) ? w_d_addr : w_i_addr;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_grant      <= PORT_I;
      r_last_grant <= PORT_D;
      r_line_buf   <= '0;
    end else begin
      r_state <= w_state_next;
      r_grant <= w_grant_next;
      if (w_done) begin
        r_last_grant <= r_grant;
        if (!w_sel_we) r_line_buf <= mem_reddata;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_grant_next = r_grant;
    w_done       = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_i_pend && w_d_pend) begin
          w_grant_next = other_port(r_last_grant);
          w_state_next = ISSUE;
        end else if (w_i_pend) begin
          w_grant_next = PORT_I;
          w_state_next = ISSUE;
        end else if (w_d_pend) begin
          w_grant_next = PORT_D;
          w_state_next = ISSUE;
        end
      end
      ISSUE: begin
        mem_write    = w_sel_we;
        mem_read     = !w_sel_we;
        w_state_next = WAIT;
      end
      WAIT: begin
        if (!mem_wait_data) begin
          w_done       = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Address/data follow the granted latch; both latches reset to zero,
  // so the bus reads zero out of reset.
  assign mem_address    = {w_sel_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  assign mem_writedata  = (r_grant == PORT_D) ? w_d_wdata : w_i_wdata;
  assign mem_burstcount = BURST;

  assign i_wait_data = w_i_pend;
  assign d_wait_data = w_d_pend;
  assign i_reddata   = r_line_buf;
  assign d_reddata   = r_line_buf;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] r_stat_i_stall, r_stat_d_stall, r_stat_conflicts;
  logic        w_conflict;

  assign w_conflict = (r_state == IDLE) && w_i_pend && w_d_pend;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_stat_i_stall   <= '0;
      r_stat_d_stall   <= '0;
      r_stat_conflicts <= '0;
    end else begin
      r_stat_i_stall   <= r_stat_i_stall   + {31'd0, w_i_pend};
      r_stat_d_stall   <= r_stat_d_stall   + {31'd0, w_d_pend};
      r_stat_conflicts <= r_stat_conflicts + {31'd0, w_conflict};
    end
  end

  assign stat_i_stall   = r_stat_i_stall;
  assign stat_d_stall   = r_stat_d_stall;
  assign stat_conflicts = r_stat_conflicts;
`else
  assign stat_i_stall   = '0;
  assign stat_d_stall   = '0;
  assign stat_conflicts = '0;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one wide-line Avalon-style burst master between the instruction-cache refill port (read-only) and the data-cache refill/writeback port (read and write).
- Sits between the two cache controllers and the memory interface.
- Latches each port's request and sequences one line transaction at a time, round-robin on contention.
- Holds the losing requester stalled through its `wait_data` flag.

Parameters:
- BURST, 5'd16: beats per line; driven on mem_burstcount.
- LINE_BITS, BURST*32: width of line data buses.
- OFFSET_BITS, 6: low address bits zeroed on mem_address (line alignment).

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- i_address  in  32  I-port line address
- i_read  in  1  I-port read request (pulse, held ≥1 cycle)
- i_wait_data  out  1  I-port busy/stall
- i_reddata  out  LINE_BITS  line data to I-port
- d_address  in  32  D-port line address
- d_read  in  1  D-port read request
- d_write  in  1  D-port write (writeback) request
- d_writedata  in  LINE_BITS  writeback line
- d_wait_data  out  1  D-port busy/stall
- d_reddata  out  LINE_BITS  line data to D-port
- mem_address  out  32  {latched_addr[31:OFFSET_BITS], zeros}
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_writedata  out  LINE_BITS  latched writeback line
- mem_burstcount  out  5  constant BURST
- mem_wait_data  in  1  memory busy
- mem_reddata  in  LINE_BITS  memory line data
- stat_i_stall  out  32  I-port stall cycle count (see Optional Feature)
- stat_d_stall  out  32  D-port stall cycle count
- stat_conflicts  out  32  contention events

Behaviour:
- Request capture, per port:
  - A cycle with the port's read (or d_write) high and pend_x=0 sets pend_x on the next edge.
  - The same edge latches address, op and (D port) writedata.
  - Requests while pend_x=1 are ignored.
  - d_read and d_write high together: treated as write.
- Wait flag: x_wait_data = pend_x (registered).
  - Rises the cycle after the request pulse, so a requester that drops read after one cycle still sees a continuous busy indication.
  - Falls in the cycle after completion.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any pend_x is set, select a grant:
    - only one pending: grant it;
    - both pending: grant the port ≠ last_grant, and count one conflict.
  - Then go to ISSUE.
  - A request captured on the same edge is eligible from the next IDLE cycle.
- ISSUE:
  - Exactly one cycle; drives mem_read or mem_write for the granted port's op.
  - mem_address and mem_writedata come from the latched copy.
  - Go to WAIT. mem_wait_data is ignored in this cycle.
- WAIT:
  - Strobes are 0; stay while mem_wait_data=1.
  - The first cycle with mem_wait_data=0 completes the transaction:
    - read: mem_reddata is captured into line_buf;
    - pend_granted is cleared;
    - last_grant ← granted;
    - go to IDLE.
- Read data:
  - i_reddata and d_reddata both output line_buf.
  - Valid for the served port from the cycle its wait_data falls, held until the next read completion.
  - Write completions do not modify line_buf.
- Latency: request pulse at cycle 0 → ISSUE at cycle 2 (uncontended) → wait_data low one cycle after memory completion. Best-case total turnaround is 4 cycles with a 1-cycle memory.
- Simultaneous events: completion of one port in the same cycle as a new request on the other: the new request is latched and granted in the following IDLE.
- Reset (resetn=0 at any edge, including mid-transaction):
  - state=IDLE; pend_i=pend_d=0; last_grant=D, so I wins the first conflict;
  - mem_read=mem_write=0; mem_address=0; mem_writedata=0; line_buf=0; wait flags 0.
  - Any memory transaction in flight is abandoned.

Optional Feature:
- Macro MEM_ARB_STATS_EN.
- When defined:
  - stat_i_stall / stat_d_stall increment every cycle the respective pend_x=1;
  - stat_conflicts increments per contended grant;
  - all counters are 32-bit wrapping and reset to 0.
- When undefined: all stat_* outputs are tied to 0 and no counter flops are instantiated.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef arb_state_e {IDLE, ISSUE, WAIT};
  - typedef port_e {PORT_I, PORT_D};
  - constants BURST_DEFAULT and OFFSET_BITS_DEFAULT.
- One sub-module, mem_arb_req_latch, instantiated twice: pending flag, address/op/data capture, clear-on-complete.

Test Plan:
- Uncontended I read: i_read pulse at addr 0x0000_1234 → mem_read one cycle with mem_address 0x0000_1200, mem_burstcount 16; memory returns pattern after 3 wait cycles → i_wait_data falls and i_reddata equals the pattern.
- Simultaneous i_read (0x1000) and d_read (0x2000) after reset → I served first, then D. D stays with d_wait_data=1 throughout. stat_conflicts=1 (with MEM_ARB_STATS_EN).
- Back-to-back contention ×4 → grants alternate I,D,I,D; no starvation.
- D writeback 0x3FC0 with data 0xA5 repeated → mem_write one cycle with mem_writedata correct; line_buf unchanged; d_wait_data falls after completion.
- resetn low during WAIT → next cycle all outputs zero, both pend flags clear; a fresh i_read completes normally.
- Repeat i_read while pend_i=1 → ignored; exactly one mem_read issued.
